// File: rtl/pipelined_adder_if.sv
// Handshake bundle for the pipelined add/subtract unit.
// The producer/consumer side uses the master modport, the adder uses slave.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Ca;
    logic             Ovf;
    logic             Zero;

    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, Sum, Ca, Ovf, Zero
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, Sum, Ca, Ovf, Zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH bits split into SEG-bit segments, one
// segment per stage, carry rippling through a register between stages.
// Operand bits not yet consumed travel upward through a shrinking register;
// finished result bits accumulate in a growing register so everything lines
// up in the last stage. Stage k therefore only stores what it still needs.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;

    // The whole pipe freezes only when a finished result is not taken.
    logic stall;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // Operand bits still to be added when entering this stage.
        localparam int OPW  = WIDTH - gi * SEG;
        // Result bits known after this stage.
        localparam int SUMW = (gi + 1) * SEG;

        logic [OPW-1:0]  a_in;
        logic [OPW-1:0]  b_in;
        logic            cin;
        logic            v_in;
        logic [SEG:0]    seg_total;
        logic [SUMW-1:0] sum_next;
        logic [SUMW-1:0] sum_reg;
        logic            carry_reg;
        logic            valid_reg;

        if (gi == 0) begin : g_first
            // Subtraction is A + ~B + 1: invert B here, the +1 is the carry-in.
            assign a_in     = bus.A;
            assign b_in     = bus.sub ? ~bus.B : bus.B;
            assign cin      = bus.sub;
            assign v_in     = bus.in_valid;
            assign sum_next = seg_total[SEG-1:0];
        end else begin : g_next
            assign a_in     = g_stage[gi-1].g_fwd.a_reg;
            assign b_in     = g_stage[gi-1].g_fwd.b_reg;
            assign cin      = g_stage[gi-1].carry_reg;
            assign v_in     = g_stage[gi-1].valid_reg;
            assign sum_next = {seg_total[SEG-1:0], g_stage[gi-1].sum_reg};
        end

        assign seg_total = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                         + {{SEG{1'b0}}, cin};

        // Stage register: valid, carry and partial sum advance together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (!stall) begin
                valid_reg <= v_in;
                carry_reg <= seg_total[SEG];
                sum_reg   <= sum_next;
            end
        end

        if (gi < STAGES - 1) begin : g_fwd
            logic [OPW-SEG-1:0] a_reg;
            logic [OPW-SEG-1:0] b_reg;

            // Skew register: carry the not-yet-added operand segments upward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (!stall) begin
                    a_reg <= a_in[OPW-1:SEG];
                    b_reg <= b_in[OPW-1:SEG];
                end
            end
        end

        if (gi == STAGES - 1) begin : g_last
            logic msb_cin;
            logic ovf_reg;
            logic zero_reg;

            // Carry into the MSB recovered from the MSB sum bit itself.
            assign msb_cin = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_total[SEG-1];

            // Flags are captured with the final sum so they stay with their item.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg  <= 1'b0;
                    zero_reg <= 1'b0;
                end else if (!stall) begin
                    ovf_reg  <= msb_cin ^ seg_total[SEG];
                    zero_reg <= (sum_next == '0);
                end
            end

            assign bus.out_valid = valid_reg;
            assign bus.Sum       = sum_reg;
            assign bus.Ca        = carry_reg;
            assign bus.Ovf       = ovf_reg;
            assign bus.Zero      = zero_reg;
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, SEG=4, latency 4).
// Reference results come from plain integer arithmetic on the operands.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int LAT    = 4;
    localparam int N_RAND = 10000;

    typedef struct packed {
        logic [15:0] sum;
        logic        ca;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    res_t q[$];

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: unsigned sum/difference plus exact signed result range test.
    function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        res_t        r;
        int          sa;
        int          sb;
        int          sr;
        logic [16:0] t;
        sa = $signed(a);
        sb = $signed(b);
        if (!s) begin
            t     = {1'b0, a} + {1'b0, b};
            r.sum = t[15:0];
            r.ca  = t[16];
            sr    = sa + sb;
        end else begin
            r.sum = a - b;
            r.ca  = (a >= b);
            sr    = sa - sb;
        end
        r.ovf  = (sr > 32767) || (sr < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h0000;
            1:       v = 16'hFFFF;
            2:       v = 16'h8000;
            3:       v = 16'h7FFF;
            default: v = 16'($urandom_range(0, 65535));
        endcase
        return v;
    endfunction

    function automatic res_t observed();
        return {bus.Sum, bus.Ca, bus.Ovf, bus.Zero};
    endfunction

    // Set inputs just after a falling edge; outputs then reflect the last rising edge.
    task automatic drive(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.sub       = s;
        bus.out_ready = ordy;
        #1;
    endtask

    // One item into an empty pipe; returns the result and cycles until out_valid.
    task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic s,
                              output res_t got, output int lat);
        drive(1'b1, a, b, s, 1'b1);
        lat = 0;
        do begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            lat++;
        end while (!bus.out_valid && lat < 16);
        got = observed();
        $display("[TB] single A=%h B=%h sub=%0d -> Sum=%h Ca=%0d Ovf=%0d Zero=%0d lat=%0d",
                 a, b, s, got.sum, got.ca, got.ovf, got.zero, lat);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.out_valid, observed()} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%0d res=%h, want all 0", bus.out_valid, observed());
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%0d out_valid=%0d, want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] av[4]  = '{16'h00FF, 16'hFFFF, 16'h8000, 16'h0001};
        logic [15:0] bv[4]  = '{16'h0001, 16'h0001, 16'h0001, 16'h0002};
        logic        sv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        res_t        ev[4]  = '{{16'h0100, 1'b0, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0, 1'b1},
                               {16'h7FFF, 1'b1, 1'b1, 1'b0}, {16'hFFFF, 1'b0, 1'b0, 1'b0}};
        res_t        got;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_single(av[i], bv[i], sv[i], got, lat);
            tests++;
            if (lat !== LAT) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, LAT);
            end
            tests++;
            if (got !== ev[i]) begin
                fails++;
                $display("FAIL directed_result[%0d]: got %h, want %h", i, got, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        res_t        e;
        int          first = -1;
        int          last  = -1;
        int          beats = 0;
        int          cyc   = 0;
        q.delete();
        while ((cyc < 8 || q.size() > 0) && cyc < 40) begin
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            drive(cyc < 8, a, b, s, 1'b1);
            if (cyc < 8) begin
                tests++;
                if (bus.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_in_ready: cycle %0d got %0d, want 1", cyc, bus.in_ready);
                end
            end
            if (bus.out_valid) begin
                tests++;
                if (first < 0) first = cyc;
                last = cyc;
                beats++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_beat: unexpected beat %h, want none", observed());
                end else begin
                    e = q.pop_front();
                    $display("[TB] b2b beat %0d Sum=%h Ca=%0d Ovf=%0d Zero=%0d", beats, bus.Sum, bus.Ca, bus.Ovf, bus.Zero);
                    if (observed() !== e) begin
                        fails++;
                        $display("FAIL b2b_beat: got %h, want %h", observed(), e);
                    end
                end
            end
            if (cyc < 8 && bus.in_ready) q.push_back(ref_op(a, b, s));
            cyc++;
        end
        tests++;
        if (beats !== 8 || last - first !== 7 || q.size() !== 0) begin
            fails++;
            $display("FAIL b2b_stream: got beats=%0d span=%0d left=%0d, want 8/7/0", beats, last - first, q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        ordy;
        res_t        held = '0;
        res_t        e;
        bit          have_held = 0;
        int          sent = 0;
        int          beats = 0;
        int          cyc = 0;
        q.delete();
        a = pick();
        b = pick();
        s = 1'($urandom_range(0, 1));
        while ((sent < 12 || q.size() > 0) && cyc < 100) begin
            ordy = !(cyc >= 6 && cyc < 11);
            drive(sent < 12, a, b, s, ordy);
            if (!ordy) begin
                tests++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_stall: in_ready=%0d out_valid=%0d, want 0/1", bus.in_ready, bus.out_valid);
                end
                if (!have_held) begin
                    held = observed();
                    have_held = 1;
                end else begin
                    tests++;
                    if (observed() !== held) begin
                        fails++;
                        $display("FAIL bp_hold: got %h, want %h", observed(), held);
                    end
                end
            end
            if (bus.out_valid && ordy) begin
                tests++;
                beats++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_beat: unexpected beat %h, want none", observed());
                end else begin
                    e = q.pop_front();
                    $display("[TB] bp beat %0d Sum=%h Ca=%0d Ovf=%0d Zero=%0d", beats, bus.Sum, bus.Ca, bus.Ovf, bus.Zero);
                    if (observed() !== e) begin
                        fails++;
                        $display("FAIL bp_beat: got %h, want %h", observed(), e);
                    end
                end
            end
            if (sent < 12 && bus.in_ready) begin
                q.push_back(ref_op(a, b, s));
                sent++;
                a = pick();
                b = pick();
                s = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        tests++;
        if (beats !== 12 || q.size() !== 0 || !have_held) begin
            fails++;
            $display("FAIL bp_total: got beats=%0d left=%0d stalled=%0d, want 12/0/1", beats, q.size(), have_held);
        end
    endtask

    task automatic test_reset_midflight();
        res_t got;
        res_t e;
        int   lat;
        int   n = 0;
        int   stale = 0;
        for (int i = 0; i < 3; i++) drive(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
        do begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            n++;
        end while (!bus.out_valid && n < 10);
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_before: out_valid=%0d, want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, observed()} !== 20'h0) begin
            fails++;
            $display("FAIL mid_async_clear: got valid=%0d res=%h, want all 0", bus.out_valid, observed());
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (bus.out_valid) stale++;
        end
        tests++;
        if (stale !== 0) begin
            fails++;
            $display("FAIL mid_stale: got %0d beats, want 0", stale);
        end
        e = ref_op(16'h1234, 16'h0FF0, 1'b1);
        run_single(16'h1234, 16'h0FF0, 1'b1, got, lat);
        tests++;
        if (lat !== LAT || got !== e) begin
            fails++;
            $display("FAIL mid_after: got lat=%0d res=%h, want lat=%0d res=%h", lat, got, LAT, e);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        iv;
        logic        ordy;
        logic        prev_stall = 1'b0;
        res_t        prev_res = '0;
        res_t        e;
        int          done = 0;
        int          cyc = 0;
        q.delete();
        while ((done < N_RAND || q.size() > 0) && cyc < 60000) begin
            iv   = (done + q.size() < N_RAND) && ($urandom_range(0, 3) != 0);
            ordy = (done >= N_RAND) || ($urandom_range(0, 3) != 0);
            a    = pick();
            b    = pick();
            s    = 1'($urandom_range(0, 1));
            drive(iv, a, b, s, ordy);
            if (prev_stall) begin
                tests++;
                if (bus.out_valid !== 1'b1 || observed() !== prev_res) begin
                    fails++;
                    $display("FAIL rand_hold: got valid=%0d res=%h, want 1 %h", bus.out_valid, observed(), prev_res);
                end
            end
            tests++;
            if (bus.in_ready !== !(bus.out_valid && !ordy)) begin
                fails++;
                $display("FAIL rand_in_ready: got %0d, want %0d", bus.in_ready, !(bus.out_valid && !ordy));
            end
            if (bus.out_valid && ordy) begin
                tests++;
                done++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_beat: unexpected beat %h, want none", observed());
                end else begin
                    e = q.pop_front();
                    $display("[TB] rand beat %0d Sum=%h Ca=%0d Ovf=%0d Zero=%0d", done, bus.Sum, bus.Ca, bus.Ovf, bus.Zero);
                    if (observed() !== e) begin
                        fails++;
                        $display("FAIL rand_beat: got %h, want %h", observed(), e);
                    end
                end
            end
            if (iv && bus.in_ready) q.push_back(ref_op(a, b, s));
            prev_stall = bus.out_valid && !ordy;
            prev_res   = observed();
            cyc++;
        end
        tests++;
        if (done !== N_RAND || q.size() !== 0) begin
            fails++;
            $display("FAIL rand_total: got %0d beats, %0d pending, want %0d/0", done, q.size(), N_RAND);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
